// File: rtl/arb_pkg.sv
// Shared definitions for the dual-requester arbiter: state encoding,
// requester IDs and the tie-break helper used by IDLE and GAP.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  // Pick the next owner from idle: lone requester wins; on a tie the side
  // that did not win last time gets the resource.
  function automatic state_t arbitrate(input logic req_a,
                                       input logic req_b,
                                       input logic last_winner);
    state_t nxt;
    nxt = ST_IDLE;
    if (req_a && req_b) begin
      nxt = (last_winner == ID_A) ? ST_GNT_B : ST_GNT_A;
    end else if (req_a) begin
      nxt = ST_GNT_A;
    end else if (req_b) begin
      nxt = ST_GNT_B;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Saturating hold counter for the arbiter.
//   clk, rst : clock, synchronous active-high reset
//   load1    : load the value 1 (start of a grant)
//   clr      : clear to 0 (no grant)
//   inc      : increment, saturating at MAX_HOLD
//   cnt      : current count
//   term     : cnt == MAX_HOLD
module hold_counter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load1,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  assign term = (cnt == CNT_MAX);

  // Clear has priority over load, load over increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= CNT_ONE;
    end else if (inc && !term) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/dual_req_arbiter.sv
// Two-requester round-robin arbiter with hold-time preemption and a
// one-cycle dead gap between grants.
//   clk, rst     : clock, synchronous active-high reset
//   req_a, req_b : level requests
//   gnt_a, gnt_b : registered one-hot grants
//   busy         : registered, gnt_a | gnt_b
//   conflict     : registered, both requests sampled high last edge
//   preempt      : pulse during the GAP after a forced release
//   hold_cnt     : cycles elapsed in the current grant, 0 otherwise
module dual_req_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             busy,
  output logic             conflict,
  output logic             preempt,
  output logic [CNT_W-1:0] hold_cnt
);

  state_t state;
  state_t state_nxt;
  logic   last_winner;
  logic   winner_nxt;
  logic   preempt_nxt;
  logic   cnt_load;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_term;

  hold_counter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold_counter (
    .clk   (clk),
    .rst   (rst),
    .load1 (cnt_load),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (hold_cnt),
    .term  (cnt_term)
  );

  // Next-state decision and counter controls.
  always_comb begin
    state_nxt   = state;
    winner_nxt  = last_winner;
    preempt_nxt = 1'b0;
    cnt_load    = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      ST_IDLE, ST_GAP: begin
        state_nxt = arbitrate(req_a, req_b, last_winner);
        if (state_nxt == ST_GNT_A) begin
          cnt_load   = 1'b1;
          winner_nxt = ID_A;
        end else if (state_nxt == ST_GNT_B) begin
          cnt_load   = 1'b1;
          winner_nxt = ID_B;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      ST_GNT_A: begin
        if (!req_a) begin
          state_nxt = ST_GAP;
          cnt_clr   = 1'b1;
        end else if (cnt_term && req_b) begin
          state_nxt   = ST_GAP;
          cnt_clr     = 1'b1;
          preempt_nxt = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_GNT_B: begin
        if (!req_b) begin
          state_nxt = ST_GAP;
          cnt_clr   = 1'b1;
        end else if (cnt_term && req_a) begin
          state_nxt   = ST_GAP;
          cnt_clr     = 1'b1;
          preempt_nxt = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  // State and registered outputs; grants are decoded from the next state
  // so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_winner <= ID_B;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      busy        <= 1'b0;
      conflict    <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_winner <= winner_nxt;
      gnt_a       <= (state_nxt == ST_GNT_A);
      gnt_b       <= (state_nxt == ST_GNT_B);
      busy        <= (state_nxt == ST_GNT_A) || (state_nxt == ST_GNT_B);
      conflict    <= req_a & req_b;
      preempt     <= preempt_nxt;
    end
  end

endmodule

// File: tb/tb_dual_req_arbiter.sv
// Directed bench for dual_req_arbiter (MAX_HOLD=8, CNT_W=8).
module tb_dual_req_arbiter;

  localparam int unsigned MAX_HOLD = 8;
  localparam int unsigned CNT_W    = 8;

  typedef struct packed {
    logic             gnt_a;
    logic             gnt_b;
    logic             busy;
    logic             conflict;
    logic             preempt;
    logic [CNT_W-1:0] cnt;
  } outs_t;

  typedef struct packed {
    logic  rst;
    logic  a;
    logic  b;
    outs_t exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_a;
  logic             req_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             busy;
  logic             conflict;
  logic             preempt;
  logic [CNT_W-1:0] hold_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  dual_req_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .req_b    (req_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .busy     (busy),
    .conflict (conflict),
    .preempt  (preempt),
    .hold_cnt (hold_cnt)
  );

  function automatic outs_t o(input logic ga, input logic gb, input logic cf,
                              input logic pr, input int c);
    outs_t r;
    r.gnt_a    = ga;
    r.gnt_b    = gb;
    r.busy     = ga | gb;
    r.conflict = cf;
    r.preempt  = pr;
    r.cnt      = CNT_W'(c);
    return r;
  endfunction

  function automatic vec_t v(input logic r, input logic a, input logic b,
                             input outs_t e);
    vec_t x;
    x.rst = r;
    x.a   = a;
    x.b   = b;
    x.exp = e;
    return x;
  endfunction

  // Apply one cycle of inputs, then compare outputs 1 time unit after the edge.
  task automatic step(input string name, input logic r, input logic a,
                      input logic b, input outs_t exp);
    outs_t act;
    rst   = r;
    req_a = a;
    req_b = b;
    @(posedge clk);
    #1;
    act = {gnt_a, gnt_b, busy, conflict, preempt, hold_cnt};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ga=%b gb=%b busy=%b cf=%b pre=%b cnt=%0d, want ga=%b gb=%b busy=%b cf=%b pre=%b cnt=%0d",
               name, act.gnt_a, act.gnt_b, act.busy, act.conflict, act.preempt, act.cnt,
               exp.gnt_a, exp.gnt_b, exp.busy, exp.conflict, exp.preempt, exp.cnt);
    end
    n_checks++;
    if (gnt_a & gnt_b) begin
      n_fail++;
      $display("FAIL %s onehot: got ga=%b gb=%b, want not both high", name, gnt_a, gnt_b);
    end
  endtask

  initial begin
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;

    // Reset with both requests high, then first grant to A.
    repeat (3) tbl.push_back(v(1, 1, 1, o(0, 0, 0, 0, 0)));
    tbl.push_back(v(0, 1, 1, o(1, 0, 1, 0, 1)));
    tbl.push_back(v(0, 0, 0, o(0, 0, 0, 0, 0)));
    tbl.push_back(v(0, 0, 0, o(0, 0, 0, 0, 0)));
    // Single requester A for 5 cycles, then gap, idle.
    for (int k = 1; k <= 5; k++) tbl.push_back(v(0, 1, 0, o(1, 0, 0, 0, k)));
    tbl.push_back(v(0, 0, 0, o(0, 0, 0, 0, 0)));
    tbl.push_back(v(0, 0, 0, o(0, 0, 0, 0, 0)));
    // Reset, then three separated ties: A, B, A.
    tbl.push_back(v(1, 0, 0, o(0, 0, 0, 0, 0)));
    tbl.push_back(v(0, 1, 1, o(1, 0, 1, 0, 1)));
    tbl.push_back(v(0, 0, 0, o(0, 0, 0, 0, 0)));
    tbl.push_back(v(0, 0, 0, o(0, 0, 0, 0, 0)));
    tbl.push_back(v(0, 1, 1, o(0, 1, 1, 0, 1)));
    tbl.push_back(v(0, 0, 0, o(0, 0, 0, 0, 0)));
    tbl.push_back(v(0, 0, 0, o(0, 0, 0, 0, 0)));
    tbl.push_back(v(0, 1, 1, o(1, 0, 1, 0, 1)));
    tbl.push_back(v(0, 0, 0, o(0, 0, 0, 0, 0)));
    tbl.push_back(v(0, 0, 0, o(0, 0, 0, 0, 0)));

    foreach (tbl[i]) begin
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].a, tbl[i].b, tbl[i].exp);
    end

    // Preemption: A held, B joins during A's grant; A gets exactly MAX_HOLD.
    step("pre_rst", 1, 0, 0, o(0, 0, 0, 0, 0));
    step("pre_a1", 0, 1, 0, o(1, 0, 0, 0, 1));
    step("pre_a2", 0, 1, 0, o(1, 0, 0, 0, 2));
    for (int k = 3; k <= 8; k++) begin
      step($sformatf("pre_a%0d", k), 0, 1, 1, o(1, 0, 1, 0, k));
    end
    step("pre_gap", 0, 1, 1, o(0, 0, 1, 1, 0));
    step("pre_b1", 0, 1, 1, o(0, 1, 1, 0, 1));
    step("pre_b2", 0, 0, 1, o(0, 1, 0, 0, 2));
    step("pre_rel", 0, 0, 0, o(0, 0, 0, 0, 0));

    // Uncontested ownership: counter saturates, no preemption.
    step("sat_rst", 1, 0, 0, o(0, 0, 0, 0, 0));
    for (int k = 1; k <= 20; k++) begin
      step($sformatf("sat%0d", k), 0, 1, 0, o(1, 0, 0, 0, (k > 8) ? 8 : k));
    end
    step("sat_rel", 0, 0, 0, o(0, 0, 0, 0, 0));

    // Reset mid-grant of B: grant drops immediately, next tie goes to A.
    step("mid_rst0", 1, 0, 0, o(0, 0, 0, 0, 0));
    step("mid_a1", 0, 1, 0, o(1, 0, 0, 0, 1));
    step("mid_gap", 0, 0, 1, o(0, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++) begin
      step($sformatf("mid_b%0d", k), 0, 0, 1, o(0, 1, 0, 0, k));
    end
    step("mid_rst", 1, 1, 1, o(0, 0, 0, 0, 0));
    step("mid_tie", 0, 1, 1, o(1, 0, 1, 0, 1));

    // Request dropped and re-raised across the gap is a fresh request.
    step("rr_drop", 0, 0, 1, o(0, 0, 0, 0, 0));
    step("rr_new", 0, 1, 1, o(0, 1, 1, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_req_arbiter.md
Name: dual_req_arbiter

Overview:
- Arbiter that shares one resource between requester A and requester B.
- The resource is the exclusive-path datapath driven by the A/B selection logic.
- Grants are one-hot and registered. Simultaneous requests are resolved round-robin. An owner is preempted after MAX_HOLD cycles if the other side is waiting.
- A one-cycle dead gap separates any two grants, so the downstream mux never sees overlapping selects.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles before forced release while the other requester waits; legal range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_a  input  1  request from requester A; level-sensitive, held while the resource is wanted.
- req_b  input  1  request from requester B; level-sensitive.
- gnt_a  output  1  registered grant to A.
- gnt_b  output  1  registered grant to B.
- busy  output  1  high while either grant is high.
- conflict  output  1  registered; high the cycle after req_a and req_b were both sampled high.
- preempt  output  1  one-cycle pulse in the GAP cycle that follows a forced release.
- hold_cnt  output  CNT_W  cycles elapsed in the current grant; 0 outside a grant.

Behaviour:
- Reset (rst high at an edge): state=IDLE; gnt_a=gnt_b=busy=conflict=preempt=0; hold_cnt=0; last_winner=B, so A wins the first tie.
- Reset mid-grant: grants drop the cycle after the reset edge. No gap cycle is inserted. Requests are re-arbitrated once rst is low.
- Invariant: gnt_a & gnt_b is never 1. busy = gnt_a | gnt_b.
- Latency: a request sampled at edge N in IDLE produces its grant, visible after edge N.
- States: IDLE, GRANT_A, GRANT_B, GAP. State is a 2-bit encoding.
- IDLE transitions:
  - Only req_a high → GRANT_A.
  - Only req_b high → GRANT_B.
  - Both high → grant the side that is not last_winner.
  - Neither high → stay in IDLE.
- Entering GRANT_X: hold_cnt loads 1; last_winner is set to X.
- GRANT_X, evaluated each edge in this priority order:
  1. req_X low → GAP (voluntary release). preempt stays 0.
  2. hold_cnt == MAX_HOLD and the other side's request is high → GAP with preempt=1.
  3. Otherwise stay in GRANT_X. hold_cnt increments and saturates at MAX_HOLD; ownership is kept indefinitely while uncontested.
- GAP: both grants low; hold_cnt=0. At the next edge, arbitrate exactly as in IDLE. Round-robin guarantees the waiting side wins after a preemption.
- A request dropped and re-raised within the GAP cycle is treated as a new request.
- conflict is computed from the sampled inputs regardless of state. It is informational only.
- Requests are assumed synchronous to clk. No synchronizers are built into this block.

Decomposition:
- Shared package arb_pkg holds:
  - the state encoding constants (ST_IDLE=2'd0, ST_GNT_A=2'd1, ST_GNT_B=2'd2, ST_GAP=2'd3);
  - the requester ID constants (ID_A=1'b0, ID_B=1'b1).
- One natural sub-module, hold_counter: CNT_W-bit saturating counter with load-1, clear, and increment-enable inputs, plus a terminal flag (cnt == MAX_HOLD). The FSM and output registers remain in the top module.

Test Plan:
- Reset: hold rst high 3 cycles with req_a=req_b=1 → all outputs 0. After rst falls, gnt_a=1 one cycle after the first sampled edge; conflict=1.
- Single requester: req_a high for 5 cycles, then low → gnt_a high 5 cycles with hold_cnt 1..5, then one GAP cycle with gnt_a=0; gnt_b never asserted.
- Tie round-robin: both requests pulsed high for 1 cycle, three times, each separated by idle → winners A, B, A in that order.
- Preemption, MAX_HOLD=8: req_a held continuously, req_b raised on A's 3rd grant cycle → gnt_a lasts exactly 8 cycles, then GAP with preempt=1, then gnt_b.
- Uncontested saturation: req_a held 20 cycles, req_b=0 → gnt_a stays high continuously; hold_cnt saturates at 8; preempt is never 1.
- Reset mid-grant: assert rst during GRANT_B with hold_cnt=4 → the next cycle shows gnt_b=0 and hold_cnt=0; the first post-reset tie goes to A.
